// File: rtl/block_stack_tos.sv
// Operand stack with top-of-stack pointer and a small variable memory.
// Feeds the ULA and function blocks with the registered top element.
module block_stack_tos #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 12,
  parameter int ULA_WIDTH   = 24,
  parameter int STACK_DEPTH = 256,
  parameter int VAR_DEPTH   = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  CMD_VALID,
  input  logic [2:0]            CMD,
  input  logic [1:0]            SEL_MUX_STACK,
  input  logic [ULA_WIDTH-1:0]  ULA_IN,
  input  logic [DATA_WIDTH-1:0] ARG_IN,
  input  logic [DATA_WIDTH-1:0] DATA_RETURN_IN,
  input  logic [ADDR_WIDTH-1:0] TOS_FUNCTION_IN,
  output logic                  CMD_READY,
  output logic [DATA_WIDTH-1:0] STACK_OUT,
  output logic [ADDR_WIDTH-1:0] REG_TOS,
  output logic                  STACK_EMPTY,
  output logic                  STACK_FULL,
  output logic                  ERR_OVERFLOW,
  output logic                  ERR_UNDERFLOW
);

  localparam int SA_W =
    (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int VA_W =
    (VAR_DEPTH > 1) ? $clog2(VAR_DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] DEPTH_C =
    ADDR_WIDTH'(STACK_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ONE = 1;
  localparam logic [ADDR_WIDTH-1:0] TWO = 2;

  localparam logic [2:0] C_NOP   = 3'd0;
  localparam logic [2:0] C_PUSH  = 3'd1;
  localparam logic [2:0] C_POP   = 3'd2;
  localparam logic [2:0] C_REPL  = 3'd3;
  localparam logic [2:0] C_DUP   = 3'd4;
  localparam logic [2:0] C_STORE = 3'd5;
  localparam logic [2:0] C_LOAD  = 3'd6;
  localparam logic [2:0] C_SET   = 3'd7;

  typedef enum logic {
    S_IDLE,
    S_LOAD
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] tos_q, tos_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic [DATA_WIDTH-1:0] stk_mem [STACK_DEPTH];
  logic [DATA_WIDTH-1:0] var_mem [VAR_DEPTH];
  logic [DATA_WIDTH-1:0] var_rdata_q;

  logic                  stk_we;
  logic [ADDR_WIDTH-1:0] stk_wptr;
  logic [DATA_WIDTH-1:0] stk_wdata;
  logic                  var_we;
  logic                  var_re;
  logic [VA_W-1:0]       var_addr;

  logic                  accept;
  logic                  is_empty;
  logic                  is_full;
  logic [DATA_WIDTH-1:0] src;
  logic [ADDR_WIDTH-1:0] tos_inc;
  logic [ADDR_WIDTH-1:0] tos_dec;
  logic [ADDR_WIDTH-1:0] pop_ptr;
  logic [ADDR_WIDTH-1:0] set_ptr;
  logic [DATA_WIDTH-1:0] pop_data;
  logic [DATA_WIDTH-1:0] set_data;

  assign CMD_READY     = (state_q == S_IDLE);
  assign accept        = CMD_VALID & CMD_READY;
  assign is_empty      = (tos_q == '0);
  assign is_full       = (tos_q == DEPTH_C);
  assign tos_inc       = tos_q + ONE;
  assign tos_dec       = tos_q - ONE;
  assign pop_ptr       = tos_q - TWO;
  assign set_ptr       = TOS_FUNCTION_IN - ONE;
  assign pop_data      = stk_mem[pop_ptr[SA_W-1:0]];
  assign set_data      = stk_mem[set_ptr[SA_W-1:0]];

  assign var_addr =
    VA_W'(32'(ARG_IN) % 32'(VAR_DEPTH));

  // Variable-memory source only exists via LOAD_VAR
  always_comb begin
    src = ARG_IN;
    unique case (SEL_MUX_STACK)
      2'd0:    src = ULA_IN[DATA_WIDTH-1:0];
      2'd3:    src = DATA_RETURN_IN;
      default: src = ARG_IN;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    tos_d     = tos_q;
    out_d     = out_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    stk_we    = 1'b0;
    stk_wptr  = tos_q;
    stk_wdata = src;
    var_we    = 1'b0;
    var_re    = 1'b0;
    if (state_q == S_LOAD) begin
      state_d   = S_IDLE;
      stk_we    = 1'b1;
      stk_wdata = var_rdata_q;
      tos_d     = tos_inc;
      out_d     = var_rdata_q;
    end else if (accept) begin
      unique case (CMD)
        C_PUSH: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            stk_we = 1'b1;
            tos_d  = tos_inc;
            out_d  = src;
          end
        end
        C_POP, C_STORE: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else begin
            var_we = (CMD == C_STORE);
            tos_d  = tos_dec;
            out_d  = (tos_dec == '0) ? '0 : pop_data;
          end
        end
        C_REPL: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else begin
            stk_we   = 1'b1;
            stk_wptr = tos_dec;
            out_d    = src;
          end
        end
        C_DUP: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else if (is_empty) begin
            unf_d = 1'b1;
          end else begin
            stk_we    = 1'b1;
            stk_wdata = out_q;
            tos_d     = tos_inc;
          end
        end
        C_LOAD: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            var_re  = 1'b1;
            state_d = S_LOAD;
          end
        end
        C_SET: begin
          if (TOS_FUNCTION_IN > DEPTH_C) begin
            ovf_d = 1'b1;
          end else begin
            tos_d = TOS_FUNCTION_IN;
            out_d = (TOS_FUNCTION_IN == '0) ?
                    '0 : set_data;
          end
        end
        C_NOP:   ;
        default: ;
      endcase
    end
    // Reset drops any in-flight write, including a pending LOAD push
    if (reset) begin
      stk_we = 1'b0;
      var_we = 1'b0;
      var_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      tos_q   <= '0;
      out_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tos_q   <= tos_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (stk_we) begin
      stk_mem[stk_wptr[SA_W-1:0]] <= stk_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (var_we) begin
      var_mem[var_addr] <= out_q;
    end
    if (var_re) begin
      var_rdata_q <= var_mem[var_addr];
    end
  end

  assign STACK_OUT     = out_q;
  assign REG_TOS       = tos_q;
  assign STACK_EMPTY   = is_empty;
  assign STACK_FULL    = is_full;
  assign ERR_OVERFLOW  = ovf_q;
  assign ERR_UNDERFLOW = unf_q;

endmodule

// File: tb/tb_block_stack_tos.sv
// Bench for block_stack_tos: directed scenarios plus
// random commands against an array-based stack model.
module tb_block_stack_tos;

  localparam int DW = 8;
  localparam int AW = 12;
  localparam int UW = 24;
  localparam int D  = 4;
  localparam int VD = 16;

  localparam logic [2:0] NOP   = 3'd0;
  localparam logic [2:0] PUSH  = 3'd1;
  localparam logic [2:0] POP   = 3'd2;
  localparam logic [2:0] REPL  = 3'd3;
  localparam logic [2:0] DUP   = 3'd4;
  localparam logic [2:0] STORE = 3'd5;
  localparam logic [2:0] LOAD  = 3'd6;
  localparam logic [2:0] SETT  = 3'd7;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          CMD_VALID = 1'b0;
  logic [2:0]    CMD = '0;
  logic [1:0]    SEL_MUX_STACK = '0;
  logic [UW-1:0] ULA_IN = '0;
  logic [DW-1:0] ARG_IN = '0;
  logic [DW-1:0] DATA_RETURN_IN = '0;
  logic [AW-1:0] TOS_FUNCTION_IN = '0;
  logic          CMD_READY;
  logic [DW-1:0] STACK_OUT;
  logic [AW-1:0] REG_TOS;
  logic          STACK_EMPTY;
  logic          STACK_FULL;
  logic          ERR_OVERFLOW;
  logic          ERR_UNDERFLOW;

  block_stack_tos #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .ULA_WIDTH(UW), .STACK_DEPTH(D),
    .VAR_DEPTH(VD)
  ) dut (
    .clk(clk), .reset(reset),
    .CMD_VALID(CMD_VALID), .CMD(CMD),
    .SEL_MUX_STACK(SEL_MUX_STACK),
    .ULA_IN(ULA_IN), .ARG_IN(ARG_IN),
    .DATA_RETURN_IN(DATA_RETURN_IN),
    .TOS_FUNCTION_IN(TOS_FUNCTION_IN),
    .CMD_READY(CMD_READY),
    .STACK_OUT(STACK_OUT), .REG_TOS(REG_TOS),
    .STACK_EMPTY(STACK_EMPTY),
    .STACK_FULL(STACK_FULL),
    .ERR_OVERFLOW(ERR_OVERFLOW),
    .ERR_UNDERFLOW(ERR_UNDERFLOW)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int            m_tos;
  logic [DW-1:0] m_out;
  logic          m_ovf;
  logic          m_unf;
  logic [DW-1:0] m_mem [D];
  logic [DW-1:0] m_var [VD];
  logic          m_pend;
  logic [DW-1:0] m_pend_val;

  task automatic model_reset();
    m_tos  = 0;
    m_out  = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
    m_pend = 1'b0;
  endtask

  task automatic model_top();
    if (m_tos == 0) m_out = '0;
    else m_out = m_mem[m_tos-1];
  endtask

  task automatic model_push(input logic [DW-1:0] v);
    m_mem[m_tos] = v;
    m_tos = m_tos + 1;
    m_out = v;
  endtask

  task automatic model_apply(
    input logic [2:0] c, input logic [1:0] s,
    input logic [UW-1:0] u, input logic [DW-1:0] a,
    input logic [DW-1:0] r, input logic [AW-1:0] t);
    logic [DW-1:0] src;
    int va;
    va = int'(a) % VD;
    if (s == 2'd0) src = u[DW-1:0];
    else if (s == 2'd3) src = r;
    else src = a;
    case (c)
      PUSH:
        if (m_tos == D) m_ovf = 1'b1;
        else model_push(src);
      POP:
        if (m_tos == 0) m_unf = 1'b1;
        else begin
          m_tos = m_tos - 1;
          model_top();
        end
      REPL:
        if (m_tos == 0) m_unf = 1'b1;
        else begin
          m_mem[m_tos-1] = src;
          m_out = src;
        end
      DUP:
        if (m_tos == D) m_ovf = 1'b1;
        else if (m_tos == 0) m_unf = 1'b1;
        else begin
          m_mem[m_tos] = m_out;
          m_tos = m_tos + 1;
        end
      STORE:
        if (m_tos == 0) m_unf = 1'b1;
        else begin
          m_var[va] = m_out;
          m_tos = m_tos - 1;
          model_top();
        end
      LOAD:
        if (m_tos == D) m_ovf = 1'b1;
        else begin
          m_pend = 1'b1;
          m_pend_val = m_var[va];
        end
      SETT:
        if (int'(t) > D) m_ovf = 1'b1;
        else begin
          m_tos = int'(t);
          model_top();
        end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1;
    CMD_VALID = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_cmd(
    input logic [2:0] c, input logic [1:0] s,
    input logic [UW-1:0] u, input logic [DW-1:0] a,
    input logic [DW-1:0] r, input logic [AW-1:0] t);
    CMD_VALID = 1'b1;
    CMD = c;
    SEL_MUX_STACK = s;
    ULA_IN = u;
    ARG_IN = a;
    DATA_RETURN_IN = r;
    TOS_FUNCTION_IN = t;
    model_apply(c, s, u, a, r, t);
    @(posedge clk); #1;
    CMD_VALID = 1'b0;
  endtask

  // second LOAD cycle: a junk command is offered and must be ignored
  task automatic finish_load();
    CMD_VALID = 1'b1;
    CMD = 3'($urandom);
    SEL_MUX_STACK = 2'($urandom);
    ARG_IN = 8'($urandom);
    TOS_FUNCTION_IN = 12'($urandom_range(0, 5));
    @(posedge clk); #1;
    CMD_VALID = 1'b0;
    if (m_pend) model_push(m_pend_val);
    m_pend = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    CMD_VALID = 1'b1;
    CMD = PUSH;
    SEL_MUX_STACK = 2'd1;
    ARG_IN = 8'h99;
    @(posedge clk); #1;
    @(posedge clk); #1;
    CMD_VALID = 1'b0;
    reset = 1'b0;
    model_reset();
    total++;
    if (REG_TOS !== 12'd0) begin
      bad++;
      $display("FAIL rst_tos got=%0h want=0", REG_TOS);
    end
    total++;
    if (STACK_OUT !== 8'h00) begin
      bad++;
      $display("FAIL rst_out got=%0h want=0", STACK_OUT);
    end
    total++;
    if ({STACK_EMPTY, STACK_FULL, CMD_READY}
        !== 3'b101) begin
      bad++;
      $display("FAIL rst_flags got=%b want=101",
        {STACK_EMPTY, STACK_FULL, CMD_READY});
    end
    total++;
    if ({ERR_OVERFLOW, ERR_UNDERFLOW} !== 2'b00) begin
      bad++;
      $display("FAIL rst_err got=%b want=00",
        {ERR_OVERFLOW, ERR_UNDERFLOW});
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    do_cmd(PUSH, 2'd1, '0, 8'h11, '0, '0);
    do_cmd(PUSH, 2'd1, '0, 8'h22, '0, '0);
    do_cmd(PUSH, 2'd1, '0, 8'h33, '0, '0);
    total++;
    if (REG_TOS !== 12'd3 || STACK_OUT !== 8'h33) begin
      bad++;
      $display("FAIL push3 got=%0h/%0h want=3/33",
        REG_TOS, STACK_OUT);
    end
    do_cmd(POP, 2'd0, '0, '0, '0, '0);
    total++;
    if (REG_TOS !== 12'd2 || STACK_OUT !== 8'h22) begin
      bad++;
      $display("FAIL pop got=%0h/%0h want=2/22",
        REG_TOS, STACK_OUT);
    end
  endtask

  task automatic test_sources();
    do_cmd(PUSH, 2'd0, 24'hABCDEF, 8'h01, '0, '0);
    total++;
    if (REG_TOS !== 12'd3 || STACK_OUT !== 8'hEF) begin
      bad++;
      $display("FAIL push_ula got=%0h/%0h want=3/ef",
        REG_TOS, STACK_OUT);
    end
    do_cmd(REPL, 2'd3, '0, 8'h01, 8'h5A, '0);
    total++;
    if (REG_TOS !== 12'd3 || STACK_OUT !== 8'h5A) begin
      bad++;
      $display("FAIL repl_ret got=%0h/%0h want=3/5a",
        REG_TOS, STACK_OUT);
    end
    do_cmd(PUSH, 2'd2, '0, 8'h77, '0, '0);
    total++;
    if (STACK_OUT !== 8'h77 || STACK_FULL !== 1'b1) begin
      bad++;
      $display("FAIL push_sel2 got=%0h/%b want=77/1",
        STACK_OUT, STACK_FULL);
    end
  endtask

  task automatic test_store_load();
    do_reset();
    do_cmd(PUSH, 2'd1, '0, 8'h42, '0, '0);
    do_cmd(STORE, 2'd0, '0, 8'd7, '0, '0);
    total++;
    if (REG_TOS !== 12'd0 || STACK_OUT !== 8'h00) begin
      bad++;
      $display("FAIL store got=%0h/%0h want=0/0",
        REG_TOS, STACK_OUT);
    end
    do_cmd(LOAD, 2'd2, '0, 8'd7, '0, '0);
    total++;
    if (CMD_READY !== 1'b0 || REG_TOS !== 12'd0) begin
      bad++;
      $display("FAIL load_busy got=%b/%0h want=0/0",
        CMD_READY, REG_TOS);
    end
    finish_load();
    total++;
    if (REG_TOS !== 12'd1 || STACK_OUT !== 8'h42 ||
        CMD_READY !== 1'b1) begin
      bad++;
      $display("FAIL load got=%0h/%0h/%b want=1/42/1",
        REG_TOS, STACK_OUT, CMD_READY);
    end
    do_cmd(LOAD, 2'd2, '0, 8'd23, '0, '0);
    finish_load();
    total++;
    if (REG_TOS !== 12'd2 || STACK_OUT !== 8'h42) begin
      bad++;
      $display("FAIL load_wrap got=%0h/%0h want=2/42",
        REG_TOS, STACK_OUT);
    end
  endtask

  task automatic test_boundaries();
    logic [DW-1:0] v [D];
    do_reset();
    for (int i = 0; i < D; i++) begin
      v[i] = 8'($urandom);
      do_cmd(PUSH, 2'd1, '0, v[i], '0, '0);
    end
    total++;
    if (STACK_FULL !== 1'b1 || ERR_OVERFLOW !== 1'b0) begin
      bad++;
      $display("FAIL full got=%b/%b want=1/0",
        STACK_FULL, ERR_OVERFLOW);
    end
    do_cmd(PUSH, 2'd1, '0, 8'hEE, '0, '0);
    total++;
    if (ERR_OVERFLOW !== 1'b1 || REG_TOS !== 12'd4 ||
        STACK_OUT !== v[D-1]) begin
      bad++;
      $display("FAIL ovf got=%b/%0h/%0h want=1/4/%0h",
        ERR_OVERFLOW, REG_TOS, STACK_OUT, v[D-1]);
    end
    do_cmd(DUP, 2'd0, '0, '0, '0, '0);
    do_cmd(LOAD, 2'd2, '0, 8'd7, '0, '0);
    total++;
    if (CMD_READY !== 1'b1 || REG_TOS !== 12'd4) begin
      bad++;
      $display("FAIL full_load got=%b/%0h want=1/4",
        CMD_READY, REG_TOS);
    end
    for (int i = 0; i < D; i++)
      do_cmd(POP, 2'd0, '0, '0, '0, '0);
    total++;
    if (STACK_EMPTY !== 1'b1 || STACK_OUT !== 8'h00 ||
        ERR_UNDERFLOW !== 1'b0) begin
      bad++;
      $display("FAIL drain got=%b/%0h/%b want=1/0/0",
        STACK_EMPTY, STACK_OUT, ERR_UNDERFLOW);
    end
    do_cmd(POP, 2'd0, '0, '0, '0, '0);
    total++;
    if (ERR_UNDERFLOW !== 1'b1 || REG_TOS !== 12'd0 ||
        STACK_OUT !== 8'h00 || ERR_OVERFLOW !== 1'b1) begin
      bad++;
      $display("FAIL unf got=%b/%0h/%0h/%b want=1/0/0/1",
        ERR_UNDERFLOW, REG_TOS, STACK_OUT, ERR_OVERFLOW);
    end
    do_reset();
    do_cmd(REPL, 2'd1, '0, 8'h12, '0, '0);
    total++;
    if (ERR_UNDERFLOW !== 1'b1 || REG_TOS !== 12'd0) begin
      bad++;
      $display("FAIL repl_empty got=%b/%0h want=1/0",
        ERR_UNDERFLOW, REG_TOS);
    end
  endtask

  task automatic test_set_tos();
    logic [DW-1:0] e [D];
    do_reset();
    for (int i = 0; i < D; i++) begin
      e[i] = 8'($urandom);
      do_cmd(PUSH, 2'd1, '0, e[i], '0, '0);
    end
    do_cmd(SETT, 2'd0, '0, '0, '0, 12'd2);
    total++;
    if (REG_TOS !== 12'd2 || STACK_OUT !== e[1]) begin
      bad++;
      $display("FAIL set2 got=%0h/%0h want=2/%0h",
        REG_TOS, STACK_OUT, e[1]);
    end
    do_cmd(SETT, 2'd0, '0, '0, '0, 12'd4);
    total++;
    if (REG_TOS !== 12'd4 || STACK_OUT !== e[3]) begin
      bad++;
      $display("FAIL set4 got=%0h/%0h want=4/%0h",
        REG_TOS, STACK_OUT, e[3]);
    end
    do_cmd(SETT, 2'd0, '0, '0, '0, 12'd5);
    total++;
    if (ERR_OVERFLOW !== 1'b1 || REG_TOS !== 12'd4) begin
      bad++;
      $display("FAIL set_ovf got=%b/%0h want=1/4",
        ERR_OVERFLOW, REG_TOS);
    end
    do_cmd(SETT, 2'd0, '0, '0, '0, 12'd0);
    total++;
    if (STACK_EMPTY !== 1'b1 || STACK_OUT !== 8'h00) begin
      bad++;
      $display("FAIL set0 got=%b/%0h want=1/0",
        STACK_EMPTY, STACK_OUT);
    end
  endtask

  task automatic test_reset_in_load();
    logic [DW-1:0] exp;
    do_reset();
    do_cmd(PUSH, 2'd1, '0, 8'h61, '0, '0);
    do_cmd(PUSH, 2'd1, '0, 8'h62, '0, '0);
    do_cmd(LOAD, 2'd2, '0, 8'd7, '0, '0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    total++;
    if (REG_TOS !== 12'd0 || STACK_OUT !== 8'h00 ||
        CMD_READY !== 1'b1) begin
      bad++;
      $display("FAIL rst_load got=%0h/%0h/%b want=0/0/1",
        REG_TOS, STACK_OUT, CMD_READY);
    end
    do_cmd(SETT, 2'd0, '0, '0, '0, 12'd3);
    exp = m_out;
    total++;
    if (STACK_OUT !== exp) begin
      bad++;
      $display("FAIL no_push got=%0h want=%0h",
        STACK_OUT, exp);
    end
  endtask

  task automatic test_random();
    logic [2:0]    c;
    logic [1:0]    s;
    logic [UW-1:0] u;
    logic [DW-1:0] a;
    logic [DW-1:0] r;
    logic [AW-1:0] t;
    do_reset();
    for (int i = 0; i < VD; i++) begin
      do_cmd(PUSH, 2'd1, '0, 8'($urandom), '0, '0);
      do_cmd(STORE, 2'd0, '0, 8'(i), '0, '0);
    end
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      c = 3'($urandom);
      s = 2'($urandom);
      u = 24'($urandom);
      a = 8'($urandom);
      r = 8'($urandom);
      t = 12'($urandom_range(0, 6));
      do_cmd(c, s, u, a, r, t);
      if (m_pend) begin
        total++;
        if (CMD_READY !== 1'b0) begin
          bad++;
          $display("FAIL rnd_busy n=%0d got=%b want=0",
            n, CMD_READY);
        end
        finish_load();
      end
      total++;
      if (REG_TOS !== 12'(m_tos)) begin
        bad++;
        $display("FAIL rnd_tos n=%0d got=%0h want=%0h",
          n, REG_TOS, m_tos);
      end
      total++;
      if (STACK_OUT !== m_out) begin
        bad++;
        $display("FAIL rnd_out n=%0d got=%0h want=%0h",
          n, STACK_OUT, m_out);
      end
      total++;
      if (STACK_EMPTY !== (m_tos == 0) ||
          STACK_FULL !== (m_tos == D)) begin
        bad++;
        $display("FAIL rnd_ef n=%0d got=%b%b tos=%0d",
          n, STACK_EMPTY, STACK_FULL, m_tos);
      end
      total++;
      if (ERR_OVERFLOW !== m_ovf ||
          ERR_UNDERFLOW !== m_unf) begin
        bad++;
        $display("FAIL rnd_err n=%0d got=%b%b want=%b%b",
          n, ERR_OVERFLOW, ERR_UNDERFLOW, m_ovf, m_unf);
      end
      total++;
      if (CMD_READY !== 1'b1) begin
        bad++;
        $display("FAIL rnd_ready n=%0d got=%b want=1",
          n, CMD_READY);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_push_pop();
    test_sources();
    test_store_load();
    test_boundaries();
    test_set_tos();
    test_reset_in_load();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
